ssd1306_spi_receiver: RTL and testbench
=======================================

// Module: ssd1306_spi_receiver
// PURPOSE
//  Responder end of the 4-wire SSD1306 OLED SPI link (csn/dc/clk/mosi + rstn): oversamples the bus on
//  clk_in, assembles MSB-first bytes and tags each byte as command or data. It tracks the controller's
//  addressing state and emits GDDRAM write strobes with column/page. Used as a loopback/scoreboard
//  target for the frequency-counter OLED driver on pico-ice and in simulation.
// PARAMETERS
//  SYNC_STAGES  2    input synchronizer depth (>=2)
//  COLS         128  display columns (col width = $clog2(COLS))
//  PAGES        8    display pages (page width = $clog2(PAGES))
// PORTS
//  clk_in          in   1   system clock; must be >= 4x oled_clk_in frequency
//  reset_in        in   1   asynchronous, active-high reset
//  oled_rstn_in    in   1   display reset (active low), asynchronous to clk_in
//  oled_csn_in     in   1   chip select (active low)
//  oled_dc_in      in   1   0 = command byte, 1 = data byte
//  oled_clk_in     in   1   SPI clock, mosi sampled on rising edge
//  oled_mosi_in    in   1   serial data, MSB first
//  byte_out        out  8   last received byte
//  byte_valid_out  out  1   1-cycle pulse: byte_out/byte_is_data_out valid
//  byte_is_data_out out 1   dc value sampled with bit 0 of the byte
//  ram_we_out      out  1   1-cycle pulse: GDDRAM write
//  ram_col_out     out  7   write column (log2 COLS)
//  ram_page_out    out  3   write page (log2 PAGES)
//  ram_data_out    out  8   write data
//  display_on_out  out  1   1 after 0xAF, 0 after 0xAE
//  frame_done_out  out  1   1-cycle pulse when pointer wraps to (col_start,page_start), horiz/vert mode
//  frame_err_out   out  1   1-cycle pulse: csn rose with 1..7 bits pending
// BEHAVIOUR
//  - Reset (reset_in or synced oled_rstn_in low): all pulses 0, byte_out/ram_* 0, display_on 0,
//    bit counter 0, FSM IDLE, mode horizontal, col range 0..COLS-1, page range 0..PAGES-1, ptr (0,0).
//    Synchronizer regs reset to csn=1, clk=0, rstn=1 (reset_in only).
//  - All bus inputs pass SYNC_STAGES flops; rising edge of synced clk detected by 1 extra flop.
//  - On detected rising edge with synced csn=0: shift in mosi, bit_cnt++. At 8th bit latch byte and
//    dc; byte_valid_out pulses the following clk_in cycle. bit_cnt wraps 7->0 (multi-byte bursts).
//  - Synced csn=1: bit_cnt forced 0; if bit_cnt was 1..7, partial byte discarded, frame_err pulse.
//    Edge and csn rise detected in the same cycle: the edge is processed first, then csn is evaluated.
//  - Command FSM (dc=0 bytes): IDLE, ARG1, ARG2, SKIP.
//    0x20 -> ARG1: mode = arg[1:0] (00 horiz, 01 vert, 10 page, 11 ignored).
//    0x21 -> ARG1 col_start, ARG2 col_end; ptr col <= col_start.
//    0x22 -> ARG1 page_start, ARG2 page_end; ptr page <= page_start.
//    0x81,0x8D,0xA8,0xD3,0xD5,0xD9,0xDA,0xDB -> SKIP one arg byte.
//    0xAE/0xAF display off/on. 0xB0-0xB7 page ptr (page mode). 0x00-0x0F / 0x10-0x1F set low / high
//    col nibble (page mode). All other commands: 0 args, ignored.
//    Args are truncated to col/page width; if end < start, end is treated as start.
//  - Data byte (dc=1): ram_we_out pulses with byte_valid_out, using the pointer before increment.
//    If FSM not IDLE it returns to IDLE (pending command abandoned), data still written.
//    Horiz: col++; at col_end col<=col_start, page++ (page_end -> page_start, frame_done).
//    Vert: page++; at page_end page<=page_start, col++ (col_end -> col_start, frame_done).
//    Page: col++; at col_end col<=col_start, page unchanged, no frame_done.
//  - oled_rstn_in low mid-byte: bit_cnt cleared, no byte emitted, no frame_err.
// TESTING
//  1. csn low, send 0xA5 dc=1 at sclk=clk_in/8 -> one byte_valid, byte_out=0xA5, is_data=1, ram_we
//     at (0,0); next byte written at col 1.
//  2. Cmds 0x21,0x02,0x03,0x22,0x01,0x01 then 3 data bytes -> writes (2,1),(3,1),(2,1);
//     frame_done pulses with the 2nd write.
//  3. csn rises after 5 bits -> frame_err pulse, no byte_valid; next full byte decoded correctly.
//  4. 0x20,0x02 (page mode), 0xB3,0x05,0x17 then 2 data -> writes at (0x75,3),(0x76,3).
//  5. 0x81 then 0xAF -> 0xAF consumed as contrast arg, display_on stays 0; another 0xAF -> display_on 1.
//  6. oled_rstn_in pulsed low after range cmds -> ranges/ptr/mode at defaults, next data at (0,0).

Source files
------------

// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: oversampling SSD1306 4-wire SPI responder that decodes bytes,
// follows the controller's addressing commands and reports GDDRAM writes.
module ssd1306_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS = 128,
  parameter int PAGES = 8,
  localparam int CW = $clog2(COLS),
  localparam int PW = $clog2(PAGES)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          oled_rstn_in,
  input  logic          oled_csn_in,
  input  logic          oled_dc_in,
  input  logic          oled_clk_in,
  input  logic          oled_mosi_in,
  output logic [7:0]    byte_out,
  output logic          byte_valid_out,
  output logic          byte_is_data_out,
  output logic          ram_we_out,
  output logic [CW-1:0] ram_col_out,
  output logic [PW-1:0] ram_page_out,
  output logic [7:0]    ram_data_out,
  output logic          display_on_out,
  output logic          frame_done_out,
  output logic          frame_err_out
);
  typedef enum logic [1:0] {IDLE, ARG1, ARG2, SKIP} state_t;
  localparam logic [1:0] HORIZ = 2'b00;
  localparam logic [1:0] VERT  = 2'b01;
  localparam logic [1:0] PAGE  = 2'b10;
  logic [SYNC_STAGES-1:0] csn_q, dc_q, sclk_q, mosi_q, rstn_q;
  logic csn_s, dc_s, sclk_s, mosi_s, rstn_s, sclk_d, csn_d;
  state_t state, state_nxt;
  logic [7:0] shreg, cmd, byte_nxt, col8, nib;
  logic [2:0] bit_cnt, cnt_after;
  logic [1:0] mode;
  logic [CW-1:0] col_start, col_end, ptr_col, arg_col, col_inc, col_n;
  logic [PW-1:0] page_start, page_end, ptr_page, arg_page, page_inc, page_n;
  logic edge_ok, byte_done, is_cmd, is_data, col_last, page_last, wrap, skip_cmd;
  assign csn_s  = csn_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rstn_s = rstn_q[SYNC_STAGES-1];
  assign col8   = 8'(ptr_col);
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      csn_q  <= '1;
      dc_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
      rstn_q <= '1;
      sclk_d <= 1'b0;
      csn_d  <= 1'b1;
    end else begin
      csn_q  <= {csn_q[SYNC_STAGES-2:0], oled_csn_in};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], oled_dc_in};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], oled_clk_in};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], oled_mosi_in};
      rstn_q <= {rstn_q[SYNC_STAGES-2:0], oled_rstn_in};
      sclk_d <= sclk_s;
      csn_d  <= csn_s;
    end
  // Edges are gated by the delayed csn so a final edge coinciding with csn rising still counts.
  always_comb begin
    edge_ok   = sclk_s & ~sclk_d & ~csn_d;
    byte_nxt  = {shreg[6:0], mosi_s};
    cnt_after = edge_ok ? bit_cnt + 3'd1 : bit_cnt;
    byte_done = edge_ok & (bit_cnt == 3'd7);
    is_cmd    = byte_done & ~dc_s;
    is_data   = byte_done & dc_s;
    arg_col   = byte_nxt[CW-1:0];
    arg_page  = byte_nxt[PW-1:0];
    col_last  = ptr_col == col_end;
    page_last = ptr_page == page_end;
    col_inc   = col_last ? col_start : ptr_col + CW'(1);
    page_inc  = page_last ? page_start : ptr_page + PW'(1);
    col_n     = (mode == VERT) ? (page_last ? col_inc : ptr_col) : col_inc;
    page_n    = (mode == HORIZ) ? (col_last ? page_inc : ptr_page) : (mode == VERT) ? page_inc : ptr_page;
    wrap      = (mode != PAGE) & col_last & page_last;
    nib       = byte_nxt[4] ? {byte_nxt[3:0], col8[3:0]} : {col8[7:4], byte_nxt[3:0]};
    skip_cmd  = byte_nxt inside {8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
    state_nxt = state;
    if (is_data)
      state_nxt = IDLE;
    else if (is_cmd)
      state_nxt = (state == IDLE) ? ((byte_nxt inside {8'h20, 8'h21, 8'h22}) ? ARG1 : skip_cmd ? SKIP : IDLE)
                : (state == ARG1 && cmd != 8'h20) ? ARG2 : IDLE;
  end
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in)
      state <= IDLE;
    else
      state <= rstn_s ? state_nxt : IDLE;
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      byte_out         <= '0;
      byte_valid_out   <= 1'b0;
      byte_is_data_out <= 1'b0;
      ram_we_out       <= 1'b0;
      ram_col_out      <= '0;
      ram_page_out     <= '0;
      ram_data_out     <= '0;
      display_on_out   <= 1'b0;
      frame_done_out   <= 1'b0;
      frame_err_out    <= 1'b0;
      shreg            <= '0;
      bit_cnt          <= '0;
      cmd              <= '0;
      mode             <= HORIZ;
      col_start        <= '0;
      col_end          <= CW'(COLS - 1);
      page_start       <= '0;
      page_end         <= PW'(PAGES - 1);
      ptr_col          <= '0;
      ptr_page         <= '0;
    end else if (!rstn_s) begin
      byte_out         <= '0;
      byte_valid_out   <= 1'b0;
      byte_is_data_out <= 1'b0;
      ram_we_out       <= 1'b0;
      ram_col_out      <= '0;
      ram_page_out     <= '0;
      ram_data_out     <= '0;
      display_on_out   <= 1'b0;
      frame_done_out   <= 1'b0;
      frame_err_out    <= 1'b0;
      shreg            <= '0;
      bit_cnt          <= '0;
      cmd              <= '0;
      mode             <= HORIZ;
      col_start        <= '0;
      col_end          <= CW'(COLS - 1);
      page_start       <= '0;
      page_end         <= PW'(PAGES - 1);
      ptr_col          <= '0;
      ptr_page         <= '0;
    end else begin
      byte_valid_out <= byte_done;
      ram_we_out     <= is_data;
      frame_done_out <= is_data & wrap;
      frame_err_out  <= csn_s & (cnt_after != 3'd0);
      bit_cnt        <= csn_s ? 3'd0 : cnt_after;
      shreg          <= edge_ok ? byte_nxt : shreg;
      if (byte_done) begin
        byte_out         <= byte_nxt;
        byte_is_data_out <= dc_s;
      end
      if (is_data) begin
        ram_col_out  <= ptr_col;
        ram_page_out <= ptr_page;
        ram_data_out <= byte_nxt;
        ptr_col      <= col_n;
        ptr_page     <= page_n;
      end
      if (is_cmd)
        case (state)
          IDLE: begin
            cmd <= byte_nxt;
            if (byte_nxt == 8'hAE) display_on_out <= 1'b0;
            if (byte_nxt == 8'hAF) display_on_out <= 1'b1;
            if (mode == PAGE && byte_nxt[7:3] == 5'b10110) ptr_page <= arg_page;
            if (mode == PAGE && byte_nxt[7:5] == 3'b000) ptr_col <= nib[CW-1:0];
          end
          ARG1: begin
            if (cmd == 8'h20 && byte_nxt[1:0] != 2'b11) mode <= byte_nxt[1:0];
            if (cmd == 8'h21) col_start <= arg_col;
            if (cmd == 8'h22) page_start <= arg_page;
          end
          ARG2: begin
            if (cmd == 8'h21) begin
              col_end <= (arg_col < col_start) ? col_start : arg_col;
              ptr_col <= col_start;
            end
            if (cmd == 8'h22) begin
              page_end <= (arg_page < page_start) ? page_start : arg_page;
              ptr_page <= page_start;
            end
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// tb_ssd1306_spi_receiver: directed byte vectors over the SPI pins with hand-computed
// decode/write expectations, plus framing-error and display-reset sequences.
module tb_ssd1306_spi_receiver;
  logic clk_in = 1'b0, reset_in = 1'b1, rstn = 1'b1, csn = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0;
  logic [7:0] byte_out, ram_data_out;
  logic       byte_valid_out, byte_is_data_out, ram_we_out, display_on_out, frame_done_out, frame_err_out;
  logic [6:0] ram_col_out;
  logic [2:0] ram_page_out;
  always #5 clk_in = ~clk_in;
  ssd1306_spi_receiver dut (
    .clk_in(clk_in), .reset_in(reset_in), .oled_rstn_in(rstn), .oled_csn_in(csn),
    .oled_dc_in(dc), .oled_clk_in(sclk), .oled_mosi_in(mosi),
    .byte_out(byte_out), .byte_valid_out(byte_valid_out), .byte_is_data_out(byte_is_data_out),
    .ram_we_out(ram_we_out), .ram_col_out(ram_col_out), .ram_page_out(ram_page_out),
    .ram_data_out(ram_data_out), .display_on_out(display_on_out),
    .frame_done_out(frame_done_out), .frame_err_out(frame_err_out)
  );
  int nv = 0, nw = 0, nfd = 0, nerr = 0;
  logic [7:0] lb = '0, ldat = '0;
  logic       ld = 1'b0;
  logic [6:0] lc = '0;
  logic [2:0] lp = '0;
  always @(negedge clk_in) begin
    if (byte_valid_out) begin nv++; lb = byte_out; ld = byte_is_data_out; end
    if (ram_we_out) begin nw++; lc = ram_col_out; lp = ram_page_out; ldat = ram_data_out; end
    if (frame_done_out) nfd++;
    if (frame_err_out) nerr++;
  end
  typedef struct packed {
    logic [7:0] b;
    logic       dc;
    logic       we;
    logic [6:0] col;
    logic [2:0] page;
    logic       fd;
    logic       disp;
  } vec_t;
  vec_t vq[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask
  task automatic send_bits(input logic [7:0] b, input logic d, input int nb);
    dc = d;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask
  task automatic send(input logic [7:0] b, input logic d);
    send_bits(b, d, 8);
    settle(12);
  endtask
  task automatic v(input logic [7:0] b, input logic d, input logic we, input logic [6:0] col,
                   input logic [2:0] page, input logic fd, input logic disp);
    vq.push_back({b, d, we, col, page, fd, disp});
  endtask
  initial begin
    int v0, w0, f0, e0;
    v(8'hA5,1,1,7'd0,3'd0,0,0); v(8'h3C,1,1,7'd1,3'd0,0,0);
    v(8'h21,0,0,0,0,0,0); v(8'h02,0,0,0,0,0,0); v(8'h03,0,0,0,0,0,0);
    v(8'h22,0,0,0,0,0,0); v(8'h01,0,0,0,0,0,0); v(8'h01,0,0,0,0,0,0);
    v(8'h11,1,1,7'd2,3'd1,0,0); v(8'h22,1,1,7'd3,3'd1,1,0); v(8'h33,1,1,7'd2,3'd1,0,0);
    v(8'h81,0,0,0,0,0,0); v(8'hAF,0,0,0,0,0,0); v(8'hAF,0,0,0,0,0,1);
    v(8'hAE,0,0,0,0,0,0); v(8'hAF,0,0,0,0,0,1);
    v(8'h20,0,0,0,0,0,1); v(8'h02,0,0,0,0,0,1); v(8'hB3,0,0,0,0,0,1);
    v(8'h05,0,0,0,0,0,1); v(8'h17,0,0,0,0,0,1);
    v(8'h44,1,1,7'h75,3'd3,0,1); v(8'h55,1,1,7'h76,3'd3,0,1);
    v(8'h21,0,0,0,0,0,1); v(8'h66,1,1,7'h77,3'd3,0,1);
    v(8'h10,0,0,0,0,0,1); v(8'h77,1,1,7'h08,3'd3,0,1);
    v(8'h03,0,0,0,0,0,1); v(8'h88,1,1,7'd3,3'd3,0,1); v(8'h99,1,1,7'd2,3'd3,0,1);
    v(8'h20,0,0,0,0,0,1); v(8'h01,0,0,0,0,0,1);
    v(8'h22,0,0,0,0,0,1); v(8'h00,0,0,0,0,0,1); v(8'h01,0,0,0,0,0,1);
    v(8'h21,0,0,0,0,0,1); v(8'h05,0,0,0,0,0,1); v(8'h06,0,0,0,0,0,1);
    v(8'hD0,1,1,7'd5,3'd0,0,1); v(8'hD1,1,1,7'd5,3'd1,0,1); v(8'hD2,1,1,7'd6,3'd0,0,1);
    v(8'hD3,1,1,7'd6,3'd1,1,1); v(8'hD4,1,1,7'd5,3'd0,0,1);
    v(8'h21,0,0,0,0,0,1); v(8'h0A,0,0,0,0,0,1); v(8'h04,0,0,0,0,0,1);
    v(8'h22,0,0,0,0,0,1); v(8'h02,0,0,0,0,0,1); v(8'h01,0,0,0,0,0,1);
    v(8'hE0,1,1,7'd10,3'd2,1,1); v(8'hE1,1,1,7'd10,3'd2,1,1);
    settle(4);
    reset_in = 1'b0;
    settle(3);
    chk("reset byte_out", byte_out, 0);
    chk("reset byte_valid", byte_valid_out, 0);
    chk("reset ram_we", ram_we_out, 0);
    chk("reset ram_col", ram_col_out, 0);
    chk("reset ram_page", ram_page_out, 0);
    chk("reset display_on", display_on_out, 0);
    chk("reset frame_err", frame_err_out, 0);
    csn = 1'b0;
    settle(6);
    foreach (vq[i]) begin
      v0 = nv; w0 = nw; f0 = nfd;
      send(vq[i].b, vq[i].dc);
      chk($sformatf("v%0d valid_cnt", i), nv - v0, 1);
      chk($sformatf("v%0d byte", i), lb, vq[i].b);
      chk($sformatf("v%0d is_data", i), ld, vq[i].dc);
      chk($sformatf("v%0d we_cnt", i), nw - w0, vq[i].we);
      if (vq[i].we) begin
        chk($sformatf("v%0d col", i), lc, vq[i].col);
        chk($sformatf("v%0d page", i), lp, vq[i].page);
        chk($sformatf("v%0d data", i), ldat, vq[i].b);
      end
      chk($sformatf("v%0d frame_done_cnt", i), nfd - f0, vq[i].fd);
      chk($sformatf("v%0d display_on", i), display_on_out, vq[i].disp);
    end
    v0 = nv; e0 = nerr;
    send_bits(8'hC3, 1'b1, 5);
    #40 csn = 1'b1;
    settle(8);
    chk("partial err_cnt", nerr - e0, 1);
    chk("partial valid_cnt", nv - v0, 0);
    csn = 1'b0;
    settle(6);
    send(8'h5A, 1'b1);
    chk("after err valid_cnt", nv - v0, 1);
    chk("after err byte", lb, 8'h5A);
    chk("after err col", lc, 10);
    chk("after err page", lp, 2);
    chk("after err err_cnt", nerr - e0, 1);
    send(8'h21, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0); send(8'hAF, 1'b0);
    chk("pre rstn display_on", display_on_out, 1);
    v0 = nv; w0 = nw; e0 = nerr;
    send_bits(8'hFF, 1'b1, 3);
    rstn = 1'b0;
    settle(6);
    rstn = 1'b1;
    settle(6);
    chk("rstn valid_cnt", nv - v0, 0);
    chk("rstn err_cnt", nerr - e0, 0);
    chk("rstn display_on", display_on_out, 0);
    chk("rstn byte_out", byte_out, 0);
    send(8'h77, 1'b1);
    chk("rstn wr1 col", lc, 0);
    chk("rstn wr1 page", lp, 0);
    chk("rstn wr1 data", ldat, 8'h77);
    send(8'h78, 1'b1);
    chk("rstn wr2 col", lc, 1);
    chk("rstn wr2 page", lp, 0);
    chk("rstn we_cnt", nw - w0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
